// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_pkg
// Purpose  : Shared types and constants for the boot-time program loader.
// Revision : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

  // Loader sequencing states
  typedef enum logic [2:0] {
    ST_HDR0 = 3'd0,
    ST_HDR1 = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  // Header is a 16-bit big-endian word count
  localparam int HDR_BYTES  = 2;
  // Payload words are 32 bits, sent MSB first
  localparam int WORD_BYTES = 4;

  // True while the loader is consuming the byte stream
  function automatic logic is_loading(input state_t s);
    return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_if
// Purpose  : Byte stream, CPU RAM port and RAM port bundle of the loader.
//            master = stream source / CPU / RAM side, slave = the loader.
// Revision : 1.0 - initial release
// ============================================================================
interface prog_loader_if #(
  parameter int SIZE = 14
);
  logic            in_valid;
  logic [7:0]      in_byte;
  logic            in_ready;
  logic            load_req;
  logic            cpu_wrEn;
  logic [SIZE-1:0] cpu_addr;
  logic [31:0]     cpu_data;
  logic            ram_wrEn;
  logic [SIZE-1:0] ram_addr;
  logic [31:0]     ram_data;
  logic            cpu_rst;
  logic            busy;
  logic            err;

  modport master (
    output in_valid, in_byte, load_req, cpu_wrEn, cpu_addr, cpu_data,
    input  in_ready, ram_wrEn, ram_addr, ram_data, cpu_rst, busy, err
  );

  modport slave (
    input  in_valid, in_byte, load_req, cpu_wrEn, cpu_addr, cpu_data,
    output in_ready, ram_wrEn, ram_addr, ram_data, cpu_rst, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/prog_loader_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : word_packer
// Purpose  : Shifts payload bytes MSB-first into a 32-bit word, pulses
//            o_word_valid for one cycle after the last byte of each word and
//            keeps a running XOR of every byte fed in.
// Revision : 1.0 - initial release
// ============================================================================
module word_packer
  import prog_loader_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        i_clear,
  input  wire logic        i_vld,
  input  wire logic [7:0]  i_byte,
  output logic             o_last,
  output logic [31:0]      o_word,
  output logic             o_word_valid,
  output logic [7:0]       o_xor
);

  localparam logic [1:0] c_LAST_PHASE = 2'(WORD_BYTES - 1);

  logic [1:0]  r_phase;
  logic [31:0] r_word;
  logic        r_word_valid;
  logic [7:0]  r_xor;

  // Current byte completes a word: the owner uses this to latch the address
  assign o_last       = i_vld && (r_phase == c_LAST_PHASE);
  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;
  assign o_xor        = r_xor;

  // Shift-in, phase count, completion pulse and checksum accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase      <= 2'd0;
      r_word       <= 32'd0;
      r_word_valid <= 1'b0;
      r_xor        <= 8'd0;
    end else if (i_clear) begin
      r_phase      <= 2'd0;
      r_word       <= 32'd0;
      r_word_valid <= 1'b0;
      r_xor        <= 8'd0;
    end else begin
      r_word_valid <= o_last;
      if (i_vld) begin
        r_phase <= r_phase + 2'd1;
        r_word  <= {r_word[23:0], i_byte};
        r_xor   <= r_xor ^ i_byte;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Boot loader in front of the CPU RAM port. Parses a counted byte
//            stream, writes packed words from address 0, verifies the XOR
//            checksum, then releases the CPU and passes its RAM port through.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int SIZE    = 14,
  parameter int TIMEOUT = 0
) (
  input wire logic    clk,
  input wire logic    rst,
  prog_loader_if.slave bus
);

  localparam logic [31:0] c_MAX_WORDS = 32'(2 ** SIZE);
  localparam logic [SIZE:0] c_WIDX_ONE = (SIZE + 1)'(1);

  state_t          r_state;
  state_t          w_nxt;
  logic            r_in_ready;
  logic            r_busy;
  logic            r_err;
  logic            r_cpu_rst;
  logic [7:0]      r_cnt_hi;
  logic [15:0]     r_nwords;
  logic [SIZE:0]   r_widx;
  logic [SIZE-1:0] r_ram_addr;

  logic            w_accept;
  logic [15:0]     w_n;
  logic            w_n_big;
  logic            w_last_word;
  logic            w_reload;
  logic            w_run;
  logic            w_tmo_hit;
  logic            w_pk_vld;
  logic            w_pk_last;
  logic [31:0]     w_pk_word;
  logic            w_pk_wv;
  logic [7:0]      w_pk_xor;

  assign w_accept    = bus.in_valid && r_in_ready;
  assign w_n         = {r_cnt_hi, bus.in_byte};
  assign w_n_big     = {16'd0, w_n} > c_MAX_WORDS;
  assign w_last_word = (32'(r_widx) + 32'd1) == {16'd0, r_nwords};
  assign w_reload    = bus.load_req && ((r_state == ST_RUN) || (r_state == ST_ERR));
  assign w_run       = (r_state == ST_RUN);
  assign w_pk_vld    = w_accept && (r_state == ST_DATA);

  word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_reload),
    .i_vld        (w_pk_vld),
    .i_byte       (bus.in_byte),
    .o_last       (w_pk_last),
    .o_word       (w_pk_word),
    .o_word_valid (w_pk_wv),
    .o_xor        (w_pk_xor)
  );

  // Inter-byte idle watchdog; HDR0 is exempt so the loader can wait forever
  generate
    if (TIMEOUT > 0) begin : g_tmo
      localparam int TW = $clog2(TIMEOUT + 1);
      localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT - 1);
      logic [TW-1:0] r_tmo;
      logic          w_active;

      assign w_active  = (r_state == ST_HDR1) || (r_state == ST_DATA) || (r_state == ST_CHK);
      assign w_tmo_hit = w_active && !w_accept && (r_tmo == c_TMO_LAST);

      // Count consecutive cycles without an accepted byte
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_tmo <= '0;
        end else if (!w_active || w_accept) begin
          r_tmo <= '0;
        end else begin
          r_tmo <= r_tmo + TW'(1);
        end
      end
    end else begin : g_no_tmo
      assign w_tmo_hit = 1'b0;
    end
  endgenerate

  // Next-state decision from the stream format and fault conditions
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_HDR0: if (w_accept) w_nxt = ST_HDR1;
      ST_HDR1: begin
        if (w_accept) begin
          if (w_n_big)            w_nxt = ST_ERR;
          else if (w_n == 16'd0)  w_nxt = ST_CHK;
          else                    w_nxt = ST_DATA;
        end else if (w_tmo_hit) begin
          w_nxt = ST_ERR;
        end
      end
      ST_DATA: begin
        if (w_pk_last && w_last_word) w_nxt = ST_CHK;
        else if (w_tmo_hit)           w_nxt = ST_ERR;
      end
      ST_CHK: begin
        if (w_accept)       w_nxt = (bus.in_byte == w_pk_xor) ? ST_RUN : ST_ERR;
        else if (w_tmo_hit) w_nxt = ST_ERR;
      end
      ST_RUN, ST_ERR: if (bus.load_req) w_nxt = ST_HDR0;
      default: w_nxt = ST_HDR0;
    endcase
  end

  // State, registered status outputs, header count, word index and write address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_HDR0;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b1;
      r_err      <= 1'b0;
      r_cpu_rst  <= 1'b1;
      r_cnt_hi   <= 8'd0;
      r_nwords   <= 16'd0;
      r_widx     <= '0;
      r_ram_addr <= '0;
    end else begin
      r_state    <= w_nxt;
      r_in_ready <= is_loading(w_nxt);
      r_busy     <= is_loading(w_nxt);
      r_err      <= (w_nxt == ST_ERR);
      r_cpu_rst  <= (w_nxt != ST_RUN);
      if ((r_state == ST_HDR0) && w_accept) begin
        r_cnt_hi <= bus.in_byte;
      end
      if ((r_state == ST_HDR1) && w_accept) begin
        r_nwords <= w_n;
        r_widx   <= '0;
      end
      if (w_pk_last) begin
        r_ram_addr <= r_widx[SIZE-1:0];
        r_widx     <= r_widx + c_WIDX_ONE;
      end
      if (w_reload) begin
        r_widx <= '0;
      end
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.busy     = r_busy;
  assign bus.err      = r_err;
  assign bus.cpu_rst  = r_cpu_rst;

  // RAM port: CPU pass-through once running, loader writes otherwise
  assign bus.ram_wrEn = w_run ? bus.cpu_wrEn : w_pk_wv;
  assign bus.ram_addr = w_run ? bus.cpu_addr : r_ram_addr;
  assign bus.ram_data = w_run ? bus.cpu_data : w_pk_word;

endmodule
`default_nettype wire
